// File: rtl/rom_map_pkg.sv
// rom_map_pkg
//   Shared definitions for the ROM download path: the region memory map
//   (inclusive base, exclusive limit), the region index enum, the loader
//   FSM state enum and the common widths.
package rom_map_pkg;

    localparam int ADDR_W  = 27;
    localparam int RGN_AW  = 18;
    localparam int NUM_RGN = 4;
    localparam int CNT_W   = 19;

    typedef logic [ADDR_W-1:0] addr_t;

    // Bit position of each region in the one-hot rgn_wr / hit vectors.
    typedef enum logic [1:0] {
        RGN_MAIN = 2'd0,
        RGN_MCU  = 2'd1,
        RGN_SCPU = 2'd2,
        RGN_GFX  = 2'd3
    } rgn_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_e;

    localparam addr_t MAIN_BASE  = 27'h000_0000;
    localparam addr_t MAIN_LIMIT = 27'h002_0000;
    localparam addr_t MCU_BASE   = 27'h002_0000;
    localparam addr_t MCU_LIMIT  = 27'h002_1000;
    localparam addr_t SCPU_BASE  = 27'h002_1000;
    localparam addr_t SCPU_LIMIT = 27'h002_9000;
    localparam addr_t GFX_BASE   = 27'h002_9000;
    localparam addr_t GFX_LIMIT  = 27'h006_9000;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating increment for the byte counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == CNT_MAX)
            return val;
        return val + 19'd1;
    endfunction

endpackage

// File: rtl/rgn_decode.sv
// rgn_decode
//   Combinational address decoder. Maps an absolute download byte address
//   onto one of the four ROM regions.
//   Ports:
//     addr      in   27  absolute byte address
//     hit       out  4   one-hot region hit, all zero when no region matches
//     rel_addr  out  18  address relative to the hit region base (0 on miss)
module rgn_decode
    import rom_map_pkg::*;
(
    input  logic [26:0] addr,
    output logic [3:0]  hit,
    output logic [17:0] rel_addr
);

    logic [26:0] offs;

    always_comb begin
        hit  = '0;
        offs = '0;
        if (addr >= MAIN_BASE && addr < MAIN_LIMIT) begin
            hit[RGN_MAIN] = 1'b1;
            offs          = addr - MAIN_BASE;
        end else if (addr >= MCU_BASE && addr < MCU_LIMIT) begin
            hit[RGN_MCU] = 1'b1;
            offs         = addr - MCU_BASE;
        end else if (addr >= SCPU_BASE && addr < SCPU_LIMIT) begin
            hit[RGN_SCPU] = 1'b1;
            offs          = addr - SCPU_BASE;
        end else if (addr >= GFX_BASE && addr < GFX_LIMIT) begin
            hit[RGN_GFX] = 1'b1;
            offs         = addr - GFX_BASE;
        end
    end

    // The largest region (gfx) is exactly 2^18 bytes, so truncation is lossless.
    assign rel_addr = offs[17:0];

endmodule

// File: rtl/rom_loader.sv
// rom_loader
//   Steers a byte-wide ioctl download stream into four ROM regions, one
//   registered write per accepted strobe, and tracks download status.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no download; waiting for ioctl_download to rise
//   LOAD  | download active; accepted writes are decoded and forwarded
//   DONE  | one cycle after download ends; pulses done, sets loaded
//
//   Ports:
//     clk_sys         in   1   system clock
//     reset           in   1   synchronous active-high reset
//     ioctl_download  in   1   download in progress
//     ioctl_addr      in   27  absolute byte address
//     ioctl_dout      in   16  download data, bits [7:0] used
//     ioctl_wr        in   1   single-cycle write strobe
//     rgn_wr          out  4   one-hot region strobe {gfx, scpu, mcu, main}
//     rgn_addr        out  18  region-relative byte address
//     rgn_data        out  8   write byte
//     busy            out  1   high in LOAD
//     loaded          out  1   sticky download-complete flag
//     done            out  1   one-cycle completion pulse
//     bad_addr        out  1   sticky: a write missed every region
//     checksum        out  8   XOR of in-region bytes of this download
module rom_loader
    import rom_map_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [26:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    input  logic        ioctl_wr,
    output logic [3:0]  rgn_wr,
    output logic [17:0] rgn_addr,
    output logic [7:0]  rgn_data,
    output logic        busy,
    output logic        loaded,
    output logic        done,
    output logic        bad_addr,
    output logic [7:0]  checksum
);

    ld_state_e          state;
    ld_state_e          state_nxt;
    logic [3:0]         dec_hit;
    logic [17:0]        dec_rel;
    logic [CNT_W-1:0]   byte_cnt;
    logic               wr_acc;
    logic               in_rgn;
    logic               load_entry;

    rgn_decode u_rgn_decode (
        .addr     (ioctl_addr),
        .hit      (dec_hit),
        .rel_addr (dec_rel)
    );

    // Writes are only taken inside LOAD; a strobe in the IDLE cycle that
    // starts a download is dropped.
    assign wr_acc     = (state == ST_LOAD) && ioctl_download && ioctl_wr;
    assign in_rgn     = |dec_hit;
    assign load_entry = (state == ST_IDLE) && ioctl_download;

    always_ff @(posedge clk_sys) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ioctl_download)  state_nxt = ST_LOAD;
            ST_LOAD: if (!ioctl_download) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_LOAD: busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Write pipeline stage. Runs independently of the FSM so a write
    // accepted in the last LOAD cycle still emerges while in DONE.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rgn_wr   <= '0;
            rgn_addr <= '0;
            rgn_data <= '0;
        end else begin
            rgn_wr <= '0;
            if (wr_acc && in_rgn) begin
                rgn_wr   <= dec_hit;
                rgn_addr <= dec_rel;
                rgn_data <= ioctl_dout[7:0];
            end
        end
    end

    // Per-download status; cleared when a new download starts.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            checksum <= '0;
            byte_cnt <= '0;
            bad_addr <= 1'b0;
            loaded   <= 1'b0;
        end else if (load_entry) begin
            checksum <= '0;
            byte_cnt <= '0;
            bad_addr <= 1'b0;
            loaded   <= 1'b0;
        end else begin
            if (wr_acc) begin
                if (in_rgn) begin
                    checksum <= checksum ^ ioctl_dout[7:0];
                    byte_cnt <= sat_inc(byte_cnt);
                end else begin
                    bad_addr <= 1'b1;
                end
            end
            if (state == ST_DONE)
                loaded <= 1'b1;
        end
    end

    // Upper data byte is not part of the download format; byte_cnt has no
    // port and is kept for probing.
    logic unused_sink;
    assign unused_sink = &{1'b0, ioctl_dout[15:8], byte_cnt};

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wr;
    logic [3:0]  rgn_wr;
    logic [17:0] rgn_addr;
    logic [7:0]  rgn_data;
    logic        busy;
    logic        loaded;
    logic        done;
    logic        bad_addr;
    logic [7:0]  checksum;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 clk_sys = ~clk_sys;

    rom_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wr       (ioctl_wr),
        .rgn_wr         (rgn_wr),
        .rgn_addr       (rgn_addr),
        .rgn_data       (rgn_data),
        .busy           (busy),
        .loaded         (loaded),
        .done           (done),
        .bad_addr       (bad_addr),
        .checksum       (checksum)
    );

    always @(negedge clk_sys) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic put_wr(input logic [26:0] addr, input logic [7:0] data);
        ioctl_addr = addr;
        ioctl_dout = {8'hEE, data};
        ioctl_wr   = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rgn_wr"},   32'(rgn_wr),   32'h0);
        check({tag, "_rgn_addr"}, 32'(rgn_addr), 32'h0);
        check({tag, "_rgn_data"}, 32'(rgn_data), 32'h0);
        check({tag, "_busy"},     32'(busy),     32'h0);
        check({tag, "_loaded"},   32'(loaded),   32'h0);
        check({tag, "_done"},     32'(done),     32'h0);
        check({tag, "_bad_addr"}, 32'(bad_addr), 32'h0);
        check({tag, "_checksum"}, 32'(checksum), 32'h0);
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        step(); step(); step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // write with download low is ignored
        put_wr(27'h0, 8'h77);
        step();
        ioctl_wr = 1'b0;
        check("idle_wr_rgn_wr", 32'(rgn_wr), 32'h0);
        check("idle_wr_busy", 32'(busy), 32'h0);
        step();
        check("idle_stays", 32'(busy), 32'h0);

        // first download
        ioctl_download = 1'b1;
        step();
        check("enter_load", 32'(busy), 32'h1);

        put_wr(27'h21000, 8'h5A);
        step();
        ioctl_wr = 1'b0;
        check("scpu_wr", 32'(rgn_wr), 32'h4);
        check("scpu_addr", 32'(rgn_addr), 32'h0);
        check("scpu_data", 32'(rgn_data), 32'h5A);
        check("scpu_csum", 32'(checksum), 32'h5A);
        step();
        check("strobe_1cyc", 32'(rgn_wr), 32'h0);
        check("hold_data", 32'(rgn_data), 32'h5A);

        put_wr(27'h20FFF, 8'h11);
        step();
        put_wr(27'h21000, 8'h22);
        check("b2b_mcu_wr", 32'(rgn_wr), 32'h2);
        check("b2b_mcu_addr", 32'(rgn_addr), 32'hFFF);
        check("b2b_mcu_data", 32'(rgn_data), 32'h11);
        step();
        ioctl_wr = 1'b0;
        check("b2b_scpu_wr", 32'(rgn_wr), 32'h4);
        check("b2b_scpu_addr", 32'(rgn_addr), 32'h0);
        check("b2b_scpu_data", 32'(rgn_data), 32'h22);
        check("b2b_csum", 32'(checksum), 32'h69);

        put_wr(27'h69000, 8'hAA);
        step();
        ioctl_wr = 1'b0;
        check("bad_rgn_wr", 32'(rgn_wr), 32'h0);
        check("bad_flag", 32'(bad_addr), 32'h1);
        check("bad_csum", 32'(checksum), 32'h69);
        check("bad_hold_data", 32'(rgn_data), 32'h22);

        put_wr(27'h68FFF, 8'h01);
        step();
        ioctl_wr = 1'b0;
        check("gfx_top_wr", 32'(rgn_wr), 32'h8);
        check("gfx_top_addr", 32'(rgn_addr), 32'h3FFFF);

        // last write immediately followed by download low
        put_wr(27'h1FFFF, 8'h80);
        step();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        check("main_top_wr", 32'(rgn_wr), 32'h1);
        check("main_top_addr", 32'(rgn_addr), 32'h1FFFF);
        step();
        check("dl1_done", 32'(done), 32'h1);
        check("dl1_busy_done", 32'(busy), 32'h0);
        step();
        check("dl1_done_1cyc", 32'(done), 32'h0);
        check("dl1_loaded", 32'(loaded), 32'h1);
        check("dl1_csum", 32'(checksum), 32'hE8);
        check("dl1_bad_sticky", 32'(bad_addr), 32'h1);
        check("dl1_done_cnt", 32'(done_cnt), 32'd1);

        // second download: fresh start, checksum 12^34^FF
        ioctl_download = 1'b1;
        step();
        check("dl2_busy", 32'(busy), 32'h1);
        check("dl2_loaded_clr", 32'(loaded), 32'h0);
        check("dl2_bad_clr", 32'(bad_addr), 32'h0);
        check("dl2_csum_clr", 32'(checksum), 32'h0);
        put_wr(27'h0, 8'h12); step();
        put_wr(27'h1, 8'h34); step();
        put_wr(27'h2, 8'hFF); step();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        step();
        step();
        check("dl2_csum", 32'(checksum), 32'hD9);
        check("dl2_loaded", 32'(loaded), 32'h1);
        check("dl2_busy_end", 32'(busy), 32'h0);
        check("dl2_done_cnt", 32'(done_cnt), 32'd2);

        // third download, reset after 10 bytes
        ioctl_download = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            put_wr(27'(i), 8'(i + 1));
            step();
        end
        ioctl_wr = 1'b0;
        check("dl3_pre_csum", 32'(checksum), 32'h0B);
        reset = 1'b1;
        put_wr(27'h10, 8'h55);
        step();
        check_all_zero("midrst");
        reset    = 1'b0;
        ioctl_wr = 1'b0;
        step();
        check("rst_reload_busy", 32'(busy), 32'h1);
        check("rst_no_done", 32'(done_cnt), 32'd2);
        check("rst_loaded", 32'(loaded), 32'h0);
        put_wr(27'h100, 8'h3C); step();
        put_wr(27'h101, 8'hC3); step();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        step();
        step();
        check("dl3_csum", 32'(checksum), 32'hFF);
        check("dl3_loaded", 32'(loaded), 32'h1);
        check("dl3_done_cnt", 32'(done_cnt), 32'd3);

        // ignored write after completion
        put_wr(27'h0, 8'h99);
        step();
        ioctl_wr = 1'b0;
        check("post_wr_rgn_wr", 32'(rgn_wr), 32'h0);
        check("post_wr_hold", 32'(rgn_data), 32'hC3);
        check("post_wr_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have port clk_sys  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port ioctl_download  input  1  download in progress.
REQ-004 SHALL have port ioctl_addr  input  27  absolute byte address of current download write.
REQ-005 SHALL have port ioctl_dout  input  16  download data; only bits [7:0] used.
REQ-006 SHALL have port ioctl_wr  input  1  single-cycle write strobe.
REQ-007 SHALL have port rgn_wr  output  4  one-hot region write strobe: [0] main, [1] mcu, [2] scpu, [3] gfx.
REQ-008 SHALL have port rgn_addr  output  18  region-relative byte address.
REQ-009 SHALL have port rgn_data  output  8  write byte.
REQ-010 SHALL have port busy  output  1  high while in LOAD state.
REQ-011 SHALL have port loaded  output  1  sticky; high after a completed download.
REQ-012 SHALL have port done  output  1  single-cycle pulse at download completion.
REQ-013 SHALL have port bad_addr  output  1  sticky; a write hit no region during current download.
REQ-014 SHALL have port checksum  output  8  XOR of all in-region bytes of last/current download.

Function
REQ-015 SHALL decode regions: main 0x00000-0x1FFFF, mcu 0x20000-0x20FFF, scpu 0x21000-0x28FFF, gfx 0x29000-0x68FFF; bounds inclusive low, exclusive high+1.
REQ-016 SHALL compute rgn_addr = ioctl_addr - region base, truncated to 18 bits.
REQ-017 SHALL register decode: rgn_wr/rgn_addr/rgn_data valid exactly 1 cycle after the ioctl_wr cycle; rgn_wr high for 1 cycle only.
REQ-018 SHALL hold rgn_addr/rgn_data stable when rgn_wr low (last written values).
REQ-019 SHALL implement FSM IDLE, LOAD, DONE.
REQ-020 IDLE->LOAD on ioctl_download=1; on entry clear checksum, bad_addr, loaded, byte counter.
REQ-021 LOAD: accept writes only when ioctl_download=1 and ioctl_wr=1; increment 19-bit byte counter per in-region write; XOR byte into checksum.
REQ-022 LOAD->DONE on ioctl_download=0; any write strobe in the pipeline stage SHALL still complete.
REQ-023 DONE: assert done for 1 cycle, set loaded, go to IDLE.
REQ-024 Writes outside all regions SHALL produce no rgn_wr, not update checksum/counter, and set bad_addr.
REQ-025 ioctl_wr while ioctl_download=0 SHALL be ignored in all states.
REQ-026 Download restart (ioctl_download rising again) from IDLE SHALL behave as a fresh download.
REQ-027 ioctl_wr on consecutive cycles SHALL each produce a rgn_wr on consecutive cycles (no back-pressure, no drops).
REQ-028 Byte counter SHALL saturate at 0x7FFFF, not wrap.

Reset
REQ-029 reset SHALL force state IDLE; rgn_wr=0, rgn_addr=0, rgn_data=0, busy=0, loaded=0, done=0, bad_addr=0, checksum=0, counter=0.
REQ-030 reset mid-LOAD SHALL abort: no done pulse, loaded stays 0; with ioctl_download still high after reset release, FSM re-enters LOAD next cycle.
REQ-031 reset SHALL override a coincident ioctl_wr (no rgn_wr the following cycle).

Structure
REQ-032 Region bases/limits, region index enum and FSM state enum SHALL live in shared package rom_map_pkg.
REQ-033 Address decode SHALL be sub-module rgn_decode (combinational: ioctl_addr -> one-hot hit, relative address).

Verification
REQ-034 Download of byte 0x5A at 0x21000 -> next cycle rgn_wr=4'b0100, rgn_addr=0, rgn_data=0x5A.
REQ-035 Writes at 0x20FFF then 0x21000 back-to-back -> rgn_wr 4'b0010 (addr 0xFFF) then 4'b0100 (addr 0) on consecutive cycles.
REQ-036 Write at 0x69000 -> no rgn_wr, bad_addr=1, checksum unchanged.
REQ-037 Bytes 0x12,0x34,0xFF to main then download low -> checksum=0xD9, one done pulse, loaded=1, busy=0.
REQ-038 reset asserted mid-download after 10 bytes -> all outputs zero, no done; download continues -> checksum covers only post-reset bytes.
REQ-039 ioctl_wr with ioctl_download=0 at 0x00000 -> no rgn_wr, state stays IDLE.
